// File: rtl/frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_pkg
// Description : Shared definitions for the LED frame buffer and its driver.
//               Holds the write-side state encoding and the default chain
//               geometry (boards, channels per board, bits per channel).
// Revision    : 1.0 - initial release
// ============================================================================
package frame_buffer_pkg;

    localparam int C_LEDBOARDS_DEF = 30;  // boards in the chain
    localparam int C_CH_PER_BOARD  = 32;  // channels driven by one board
    localparam int C_BPC_DEF       = 12;  // bits per channel

    // Write-side fill state of the back bank
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // waiting for the SOF word of a new frame
        S_FILL = 2'd1,  // storing channels 1..N-1
        S_FULL = 2'd2   // complete frame held, waiting for the latch pulse
    } state_t;

endpackage : frame_buffer_pkg
`default_nettype wire

// File: rtl/frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_if
// Description : Host write stream and driver read port of the frame buffer.
//               master : host loader + LED driver side (drives words/address)
//               slave  : frame buffer side (returns ready and read data)
//   i_wr_valid / i_wr_sof / i_wr_data / o_wr_ready : channel write stream
//   i_rd_addr / o_rd_data                          : front-bank read port
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_buffer_if #(
    parameter int C_ADDR_W = 10,
    parameter int C_BPC    = 12
) ();

    logic                i_wr_valid;
    logic                i_wr_sof;
    logic [C_BPC-1:0]    i_wr_data;
    logic                o_wr_ready;
    logic [C_ADDR_W-1:0] i_rd_addr;
    logic [C_BPC-1:0]    o_rd_data;

    modport master (
        output i_wr_valid, i_wr_sof, i_wr_data, i_rd_addr,
        input  o_wr_ready, o_rd_data
    );

    modport slave (
        input  i_wr_valid, i_wr_sof, i_wr_data, i_rd_addr,
        output o_wr_ready, o_rd_data
    );

endinterface : frame_buffer_if
`default_nettype wire

// File: rtl/frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : frame_ram
// Description : Simple dual-port synchronous RAM, one write port and one
//               registered read port. No reset on the array or the read
//               register so that it maps onto block RAM.
//   i_clk                      : clock
//   i_we / i_waddr / i_wdata   : write port
//   i_raddr / o_rdata          : read port, data one cycle after address
// Revision    : 1.0 - initial release
// ============================================================================
module frame_ram #(
    parameter int C_AW = 11,
    parameter int C_DW = 12
) (
    input  wire logic            i_clk,
    input  wire logic            i_we,
    input  wire logic [C_AW-1:0] i_waddr,
    input  wire logic [C_DW-1:0] i_wdata,
    input  wire logic [C_AW-1:0] i_raddr,
    output logic      [C_DW-1:0] o_rdata
);

    logic [C_DW-1:0] r_mem [0:(1 << C_AW)-1];
    logic [C_DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : frame_ram
`default_nettype wire

// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer
// Description : Double-buffered pixel store feeding the LED serial driver.
//               Host words fill the back bank in order; the driver reads the
//               front bank with one cycle latency. Banks swap only on i_lat
//               once the back bank holds a complete frame, so the driver
//               never sees a torn frame.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   bus (slave)     : write stream + front-bank read port
//   i_lat           : driver latch pulse, swap point
//   o_frame_valid   : a complete frame has been presented at least once
//   o_err           : sticky short-frame / out-of-sequence SOF flag
//   o_frame_cnt     : swap counter, wraps at 255
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int C_LEDBOARDS = C_LEDBOARDS_DEF,
    parameter int C_BPC       = C_BPC_DEF,
    parameter int C_CHANNELS  = C_LEDBOARDS * C_CH_PER_BOARD,
    parameter int C_ADDR_W    = $clog2(C_CHANNELS)
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    frame_buffer_if.slave     bus,
    input  wire logic         i_lat,
    output logic              o_frame_valid,
    output logic              o_err,
    output logic [7:0]        o_frame_cnt
);

    localparam logic [C_ADDR_W-1:0] C_LAST = C_ADDR_W'(C_CHANNELS - 1);
    localparam logic [C_ADDR_W-1:0] C_ONE  = C_ADDR_W'(1);

    state_t              r_state;
    logic [C_ADDR_W-1:0] r_addr;
    logic                r_front;
    logic                r_wr_ready;
    logic                r_frame_valid;
    logic                r_err;
    logic [7:0]          r_frame_cnt;
    logic                r_rd_zero;

    logic                w_acc;
    logic                w_we;
    logic                w_rd_oob;
    logic [C_ADDR_W-1:0] w_wr_chan;
    logic [C_ADDR_W:0]   w_waddr;
    logic [C_ADDR_W:0]   w_raddr;
    logic [C_BPC-1:0]    w_ram_q;

    // A word is consumed whenever ready is high, but in S_IDLE only an SOF
    // word is actually stored; non-SOF words there are dropped.
    assign w_acc     = bus.i_wr_valid & r_wr_ready;
    assign w_we      = w_acc & (bus.i_wr_sof | (r_state == S_FILL));
    assign w_wr_chan = bus.i_wr_sof ? '0 : r_addr;

    // Bank select is the RAM address MSB: writes go to the back bank,
    // reads to the front bank, so the two ports never share a bank.
    assign w_waddr = {~r_front, w_wr_chan};
    assign w_raddr = {r_front, bus.i_rd_addr};

    // Out-of-range reads only exist when the channel count is not a power
    // of two; otherwise every address value is a real channel.
    generate
        if (C_CHANNELS < (1 << C_ADDR_W)) begin : g_oob_chk
            assign w_rd_oob = (bus.i_rd_addr > C_LAST);
        end else begin : g_oob_none
            assign w_rd_oob = 1'b0;
        end
    endgenerate

    // Banks are power-of-two sized because the bank bit sits above a full
    // C_ADDR_W-wide channel address; only C_CHANNELS entries per bank are used.
    frame_ram #(
        .C_AW (C_ADDR_W + 1),
        .C_DW (C_BPC)
    ) u_frame_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.i_wr_data),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_front       <= 1'b0;
            r_wr_ready    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_rd_zero     <= 1'b1;
        end else begin
            // Qualifier travels alongside the RAM read register so the mask
            // lines up with the address it belongs to.
            r_rd_zero <= ~r_frame_valid | w_rd_oob;

            case (r_state)
                S_IDLE: begin
                    r_wr_ready <= 1'b1;
                    if (w_acc) begin
                        if (bus.i_wr_sof) begin
                            r_addr  <= C_ONE;
                            r_state <= S_FILL;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    if (w_acc) begin
                        if (bus.i_wr_sof) begin
                            // Restart: the SOF word already went to channel 0
                            r_err  <= 1'b1;
                            r_addr <= C_ONE;
                        end else if (r_addr == C_LAST) begin
                            r_state    <= S_FULL;
                            r_wr_ready <= 1'b0;
                        end else begin
                            r_addr <= r_addr + C_ONE;
                        end
                    end
                end

                S_FULL: begin
                    if (i_lat) begin
                        r_front       <= ~r_front;
                        r_frame_valid <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 8'd1;
                        r_addr        <= '0;
                        r_state       <= S_IDLE;
                        r_wr_ready    <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_wr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_wr_ready = r_wr_ready;
    assign bus.o_rd_data  = r_rd_zero ? '0 : w_ram_q;
    assign o_frame_valid  = r_frame_valid;
    assign o_err          = r_err;
    assign o_frame_cnt    = r_frame_cnt;

endmodule : frame_buffer
`default_nettype wire

// File: tb/tb_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer
// Description : Self-checking bench for frame_buffer with a one-board chain
//               (32 channels). A frame-level model (front-frame array plus a
//               queue of words for the frame being assembled) predicts every
//               output on every cycle; directed steps add explicit checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer;

    localparam int C_CH = 32;
    localparam int C_AW = 5;
    localparam int C_DW = 12;

    logic       clk;
    logic       rst_n;
    logic       lat;
    logic       fv;
    logic       err;
    logic [7:0] cnt;

    frame_buffer_if #(.C_ADDR_W(C_AW), .C_BPC(C_DW)) bus ();

    frame_buffer #(
        .C_LEDBOARDS (1),
        .C_BPC       (C_DW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .bus           (bus),
        .i_lat         (lat),
        .o_frame_valid (fv),
        .o_err         (err),
        .o_frame_cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (frame level) ----------------
    logic [C_DW-1:0] m_front [C_CH];
    logic [C_DW-1:0] m_back [$];
    bit              m_full;
    bit              m_valid;
    bit              m_err;
    bit              m_ready;
    logic [7:0]      m_cnt;
    logic [C_DW-1:0] exp_rd;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_back.delete();
        m_full  = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ready = 1'b0;
        m_cnt   = 8'd0;
        exp_rd  = '0;
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare
    // every output shortly after the edge.
    task automatic tick();
        bit rst_seen;
        rst_seen = rst_n;
        exp_rd = m_valid ? m_front[bus.i_rd_addr] : '0;
        if (lat && m_full) begin
            for (int i = 0; i < C_CH; i++) m_front[i] = m_back[i];
            m_back.delete();
            m_full  = 1'b0;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 8'd1;
        end else if (bus.i_wr_valid && m_ready) begin
            if (bus.i_wr_sof) begin
                if (m_back.size() != 0) m_err = 1'b1;
                m_back.delete();
                m_back.push_back(bus.i_wr_data);
            end else if (m_back.size() == 0) begin
                m_err = 1'b1;
            end else begin
                m_back.push_back(bus.i_wr_data);
            end
            if (m_back.size() == C_CH) m_full = 1'b1;
        end
        m_ready = rst_seen ? !m_full : 1'b0;
        @(posedge clk);
        #1;
        check("wr_ready", 32'(bus.o_wr_ready), 32'(m_ready));
        check("frame_valid", 32'(fv), 32'(m_valid));
        check("err", 32'(err), 32'(m_err));
        check("frame_cnt", 32'(cnt), 32'(m_cnt));
        check("rd_data", 32'(bus.o_rd_data), 32'(exp_rd));
    endtask

    task automatic send_word(input logic [C_DW-1:0] d, input bit sof, input bit do_lat);
        if ($urandom_range(0, 3) == 0) begin
            bus.i_rd_addr = C_AW'($urandom_range(0, C_CH - 1));
            tick();
        end
        bus.i_wr_valid = 1'b1;
        bus.i_wr_sof   = sof;
        bus.i_wr_data  = d;
        lat            = do_lat;
        bus.i_rd_addr  = C_AW'($urandom_range(0, C_CH - 1));
        tick();
        bus.i_wr_valid = 1'b0;
        bus.i_wr_sof   = 1'b0;
        lat            = 1'b0;
    endtask

    // rnd_lat scatters ignored latch pulses through the fill
    task automatic send_frame(input int base, input int n, input bit rnd_data,
                              input bit lat_last, input bit rnd_lat);
        logic [31:0] d;
        bit          l;
        for (int i = 0; i < n; i++) begin
            d = rnd_data ? $urandom : 32'(base + i);
            l = (lat_last && i == n - 1) || (rnd_lat && $urandom_range(0, 4) == 0);
            send_word(d[C_DW-1:0], i == 0, l);
        end
    endtask

    task automatic pulse_lat();
        lat = 1'b1;
        tick();
        lat = 1'b0;
    endtask

    task automatic read_at(input int a, input int exp, input string tag);
        bus.i_rd_addr = C_AW'(a);
        tick();
        check(tag, 32'(bus.o_rd_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        lat            = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_sof   = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_addr  = '0;
        model_reset();
        for (int i = 0; i < C_CH; i++) m_front[i] = '0;

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(bus.o_wr_ready), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(bus.o_wr_ready), 32'd1);

        // Read before any frame, latch with nothing buffered
        read_at(5, 0, "rd_before_frame");
        check("fv_before_frame", 32'(fv), 32'd0);
        pulse_lat();
        tick();
        check("cnt_no_swap", 32'(cnt), 32'd0);

        // Frame 1
        send_frame(32'h100, C_CH, 1'b0, 1'b0, 1'b0);
        check("ready_drop_full", 32'(bus.o_wr_ready), 32'd0);
        pulse_lat();
        read_at(7, 32'h107, "f1_addr7");
        check("f1_cnt", 32'(cnt), 32'd1);
        check("f1_fv", 32'(fv), 32'd1);

        // Frame 2 buffered but not latched
        send_frame(32'h200, C_CH, 1'b0, 1'b0, 1'b0);
        read_at(7, 32'h107, "f2_held_old");
        pulse_lat();
        read_at(7, 32'h207, "f2_addr7");
        check("f2_cnt", 32'(cnt), 32'd2);

        // Short frame then restart
        send_frame(32'h250, 10, 1'b0, 1'b0, 1'b0);
        send_frame(32'h300, C_CH, 1'b0, 1'b0, 1'b0);
        pulse_lat();
        read_at(3, 32'h303, "restart_addr3");
        check("restart_err", 32'(err), 32'd1);

        // Latch coincident with last write is ignored
        send_frame(32'h400, C_CH, 1'b0, 1'b1, 1'b0);
        tick();
        check("lat_on_last_noswap", 32'(cnt), 32'd3);
        read_at(9, 32'h309, "lat_on_last_old");
        pulse_lat();
        read_at(9, 32'h409, "lat_after_full");
        check("lat_after_full_cnt", 32'(cnt), 32'd4);

        // Randomized frames with stray latch pulses and random reads
        for (int f = 0; f < 4; f++) begin
            send_frame(0, C_CH, 1'b1, 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) begin
                bus.i_rd_addr = C_AW'($urandom_range(0, C_CH - 1));
                tick();
            end
            pulse_lat();
            for (int k = 0; k < 6; k++) begin
                bus.i_rd_addr = C_AW'($urandom_range(0, C_CH - 1));
                tick();
            end
        end
        check("rand_cnt", 32'(cnt), 32'd8);

        // Asynchronous reset mid-fill at word 20
        send_frame(0, 20, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.o_wr_ready), 32'd0);
        check("arst_rd", 32'(bus.o_rd_data), 32'd0);
        check("arst_fv", 32'(fv), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_cnt", 32'(cnt), 32'd0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Non-SOF word in idle is dropped and flagged
        send_word(12'h0AA, 1'b0, 1'b0);
        check("idle_nosof_err", 32'(err), 32'd1);

        send_frame(32'h500, C_CH, 1'b0, 1'b0, 1'b0);
        pulse_lat();
        read_at(0, 32'h500, "post_rst_addr0");
        read_at(31, 32'h51F, "post_rst_addr31");
        check("post_rst_cnt", 32'(cnt), 32'd1);
        for (int k = 0; k < 8; k++) begin
            bus.i_rd_addr = C_AW'($urandom_range(0, C_CH - 1));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_frame_buffer
`default_nettype wire
